// File: rtl/seq_borrow_skip_subtractor.sv
// Multi-cycle subtractor: diff = a - b, processed one BLOCK-bit slice per clock, LSB slice first.
// Each slice is a ripple-borrow chain with a borrow-skip bypass. When every bit pair in the
// slice is equal, the slice borrow-out is taken straight from its borrow-in.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request, sampled only while not busy (IDLE or DONE)
//   a, b      minuend / subtrahend, latched with an accepted start
//   busy      high while slices are being computed
//   done      one-cycle pulse; results are valid from this cycle on
//   diff      a - b modulo 2^WIDTH
//   bout      final borrow (a < b unsigned)
//   ovf       signed overflow
//   zero      diff == 0
//   skip_mask bit k set when slice k took the skip path
module seq_borrow_skip_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BLOCK = 4,
  parameter int unsigned NBLK  = WIDTH / BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [NBLK-1:0]  skip_mask
);

  localparam int unsigned KW = (NBLK > 1) ? $clog2(NBLK) : 1;

  if (WIDTH == 0 || BLOCK == 0 || (WIDTH % BLOCK) != 0 || NBLK != WIDTH / BLOCK) begin : g_bad_param
    $error("WIDTH must be a positive multiple of BLOCK and NBLK must equal WIDTH/BLOCK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [NBLK-1:0]  skip_q, skip_d;

  // Current slice datapath
  logic [BLOCK-1:0] slice_a, slice_b, slice_diff;
  logic [BLOCK:0]   br_chain;
  logic             slice_prop;
  logic             slice_bout;

  assign slice_a = a_q[k_q*BLOCK +: BLOCK];
  assign slice_b = b_q[k_q*BLOCK +: BLOCK];

  always_comb begin
    br_chain    = '0;
    br_chain[0] = borrow_q;
    slice_prop  = 1'b1;
    slice_diff  = '0;
    for (int i = 0; i < BLOCK; i++) begin
      slice_diff[i]  = slice_a[i] ^ slice_b[i] ^ br_chain[i];
      br_chain[i+1]  = (~slice_a[i] & slice_b[i]) | (~(slice_a[i] ^ slice_b[i]) & br_chain[i]);
      slice_prop     = slice_prop & ~(slice_a[i] ^ slice_b[i]);
    end
  end

  // Skip path: an all-propagate slice passes its borrow-in straight through. The ripple chain
  // yields the same value; the mux only shortens the critical path.
  assign slice_bout = slice_prop ? borrow_q : br_chain[BLOCK];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    k_d      = k_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    skip_d   = skip_q;
    unique case (state_q)
      // DONE accepts a new start exactly like IDLE so back-to-back operations have no bubble.
      StIdle, StDone: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          k_d      = '0;
          skip_d   = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        diff_d[k_q*BLOCK +: BLOCK] = slice_diff;
        borrow_d                   = slice_bout;
        skip_d[k_q]                = slice_prop;
        if (k_q == KW'(NBLK - 1)) begin
          state_d = StDone;
          bout_d  = slice_bout;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (diff_d == '0);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      skip_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      k_q      <= k_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      skip_q   <= skip_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign skip_mask = skip_q;

endmodule

// File: tb/tb_seq_borrow_skip_subtractor.sv
// Directed bench for seq_borrow_skip_subtractor with default parameters (WIDTH=8, BLOCK=4).
module tb_seq_borrow_skip_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, bout, ovf, zero;
  logic [7:0] diff;
  logic [1:0] skip_mask;

  int tests_run = 0;
  int tests_failed = 0;

  seq_borrow_skip_subtractor #(
    .WIDTH(8),
    .BLOCK(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf),
    .zero     (zero),
    .skip_mask(skip_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic exp_busy, input logic exp_done);
    check({tag, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
    check({tag, " done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  task automatic check_res(input string tag, input logic [7:0] e_diff, input logic e_bout,
                           input logic e_ovf, input logic e_zero, input logic [1:0] e_skip);
    check({tag, " diff"}, {24'd0, diff}, {24'd0, e_diff});
    check({tag, " bout"}, {31'd0, bout}, {31'd0, e_bout});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    check({tag, " zero"}, {31'd0, zero}, {31'd0, e_zero});
    check({tag, " skip"}, {30'd0, skip_mask}, {30'd0, e_skip});
  endtask

  // One start pulse from IDLE: busy for two cycles, a single done pulse, then results hold.
  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [7:0] e_diff, input logic e_bout, input logic e_ovf,
                        input logic e_zero, input logic [1:0] e_skip);
    a = op_a;
    b = op_b;
    start = 1'b1;
    step();
    start = 1'b0;
    a = ~op_a;
    b = ~op_b;
    check_ctrl({tag, " run0"}, 1'b1, 1'b0);
    step();
    check_ctrl({tag, " run1"}, 1'b1, 1'b0);
    step();
    check_ctrl({tag, " donecyc"}, 1'b0, 1'b1);
    check_res(tag, e_diff, e_bout, e_ovf, e_zero, e_skip);
    step();
    check_ctrl({tag, " after"}, 1'b0, 1'b0);
    check_res({tag, " hold"}, e_diff, e_bout, e_ovf, e_zero, e_skip);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    #2;
    check_ctrl("reset", 1'b0, 1'b0);
    check_res("reset", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    #10;
    rst = 1'b0;
    step();
    check_ctrl("idle", 1'b0, 1'b0);

    run_op("sub35_12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0, 2'b00);
    run_op("sub00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 2'b10);
    run_op("sub80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 2'b00);
    run_op("sub7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 2'b01);
    run_op("subA5_A5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 2'b11);

    // start held high, operands changing every cycle; only DONE-cycle values are accepted.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    step();
    check_ctrl("b2b op1 run0", 1'b1, 1'b0);
    a = 8'hFF;
    b = 8'h33;
    step();
    check_ctrl("b2b op1 run1", 1'b1, 1'b0);
    a = 8'hAA;
    b = 8'h55;
    step();
    check_ctrl("b2b op1 done", 1'b0, 1'b1);
    check_res("b2b op1", 8'h0F, 1'b0, 1'b0, 1'b0, 2'b00);
    a = 8'h35;
    b = 8'h12;
    step();
    check_ctrl("b2b op2 run0", 1'b1, 1'b0);
    a = 8'h00;
    b = 8'h00;
    step();
    check_ctrl("b2b op2 run1", 1'b1, 1'b0);
    a = 8'h11;
    b = 8'hEE;
    step();
    check_ctrl("b2b op2 done", 1'b0, 1'b1);
    check_res("b2b op2", 8'h23, 1'b0, 1'b0, 1'b0, 2'b00);
    start = 1'b0;
    step();
    check_ctrl("b2b idle", 1'b0, 1'b0);
    check_res("b2b hold", 8'h23, 1'b0, 1'b0, 1'b0, 2'b00);

    // Leave non-zero results, then abort an operation with reset in its first RUN cycle.
    run_op("pre_abort", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 2'b10);
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    step();
    start = 1'b0;
    check_ctrl("abort run0", 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_ctrl("abort async", 1'b0, 1'b0);
    check_res("abort async", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_ctrl("abort no done", 1'b0, 1'b0);
    end
    run_op("post_abort", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
